pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program sequencer for the 9-bit-ISA core. It generalises the plain program counter with the following features:
- a branch-target lookup table
- a call/return stack
- stall support
- explicit IDLE/RUN/HALTED/FAULT states
- cycle and retired-instruction counters

It sits between the control decoder (decoded op kind, target index) and the instruction ROM (PC output), and drives the core's halt flag.

Parameters:
PC_W, 10, program counter width; ROM depth is 2**PC_W
LUT_AW, 3, branch-target LUT address width; 2**LUT_AW entries of PC_W bits
STACK_D, 4, return-stack depth (entries), >=1
CNT_W, 16, cycle/retired counter width

Ports:
CLK  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  synchronous init/restart, active high
stall  input  1  hold PC this cycle (e.g. multi-cycle memory op)
op_kind  input  3  decoded op: 0 NEXT, 1 JUMP, 2 BEQ, 3 BNE, 4 CALL, 5 RET, 6 HALT, 7 reserved(=NEXT)
equal  input  1  ALU EQUAL flag, sampled for BEQ/BNE
target_idx  input  LUT_AW  branch-target LUT index
lut_we  input  1  LUT write enable (honoured only in IDLE/HALTED)
lut_waddr  input  LUT_AW  LUT write address
lut_wdata  input  PC_W  LUT write data
PC  output  PC_W  current instruction address
halt  output  1  high in IDLE, HALTED, FAULT
fault  output  1  high in FAULT (stack overflow/underflow)
sp  output  $clog2(STACK_D+1)  return-stack occupancy
cycle_ct  output  CNT_W  cycles spent in RUN
instr_ct  output  CNT_W  instructions retired

Behaviour:
- reset_n low (async): state=IDLE, PC=0, sp=0, cycle_ct=0, instr_ct=0, fault=0, halt=1. LUT contents are not reset: all entries cleared to 0 synchronously on first CLK while reset_n low, else undefined-free via reset loop.
- States: IDLE -> RUN on start. RUN -> HALTED on retired HALT. RUN -> FAULT on stack error. HALTED/FAULT -> RUN on start. start in any state (incl. RUN) forces RUN, PC=0, sp=0, counters=0, fault=0 on next edge.
- RUN, stall=1: PC and sp hold, cycle_ct+1, instr_ct holds, op ignored.
- RUN, stall=0 (instruction retires): instr_ct+1, cycle_ct+1, next PC per op_kind:
  - NEXT/reserved: PC+1.
  - JUMP: LUT[target_idx].
  - BEQ: equal ? LUT[target_idx] : PC+1.
  - BNE: !equal ? LUT[target_idx] : PC+1.
  - CALL: push PC+1, PC=LUT[target_idx]. If sp==STACK_D: overflow -> FAULT, PC holds, no push.
  - RET: PC=top, pop. If sp==0: underflow -> FAULT, PC holds.
  - HALT: PC holds; state HALTED. This retirement counts in instr_ct.
- PC arithmetic modulo 2**PC_W (PC = all-ones + 1 wraps to 0, no fault).
- Counters saturate at all-ones; they never wrap.
- IDLE/HALTED/FAULT: PC, sp and counters frozen; op inputs ignored.
- LUT write: synchronous, at most one per cycle. Ignored in RUN and FAULT. Reads are combinational.
- start has priority over stall and op_kind; reset_n has priority over everything.
- halt and fault are registered state decodes: halt rises on the edge that retires HALT.

Test Plan:
- Reset/start: pulse reset_n low mid-RUN -> PC=0, halt=1, counters 0 immediately. Then start=1 one cycle -> RUN, PC=0; 3 NEXT -> PC=3, instr_ct=3, cycle_ct=3.
- Branch: LUT[2]=0x040 in IDLE. In RUN, BEQ idx2 with equal=0 -> PC+1; with equal=1 -> PC=0x040. BNE with equal=0 -> 0x040.
- Call/return: LUT[1]=0x100, CALL idx1 at PC=5 -> PC=0x100, sp=1. RET -> PC=6, sp=0. Nest STACK_D calls then one more CALL -> fault=1, halt=1, PC unchanged, sp=4.
- Underflow: RET with sp=0 -> FAULT. Then start -> RUN, PC=0, fault=0.
- Stall/halt: stall 2 cycles during NEXT -> PC unchanged, cycle_ct+2, instr_ct+0. HALT at PC=7 -> halt=1, PC=7, instr_ct includes HALT, counters frozen thereafter.
- Wrap/saturate: PC_W=4, PC=15 NEXT -> 0, no fault. CNT_W=4: run 20 cycles -> cycle_ct=15. lut_we in RUN -> LUT unchanged.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program sequencer with branch LUT, return stack, run-state FSM and counters
module pc_sequencer #(
   parameter int PC_W    = 10,
   parameter int LUT_AW  = 3,
   parameter int STACK_D = 4,
   parameter int CNT_W   = 16,
   localparam int SP_W   = $clog2(STACK_D + 1)
) (
   input  logic              CLK,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stall,
   input  logic [2:0]        op_kind,
   input  logic              equal,
   input  logic [LUT_AW-1:0] target_idx,
   input  logic              lut_we,
   input  logic [LUT_AW-1:0] lut_waddr,
   input  logic [PC_W-1:0]   lut_wdata,
   output logic [PC_W-1:0]   PC,
   output logic              halt,
   output logic              fault,
   output logic [SP_W-1:0]   sp,
   output logic [CNT_W-1:0]  cycle_ct,
   output logic [CNT_W-1:0]  instr_ct
);

   localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

   localparam logic [2:0] OP_JUMP = 3'd1;
   localparam logic [2:0] OP_BEQ  = 3'd2;
   localparam logic [2:0] OP_BNE  = 3'd3;
   localparam logic [2:0] OP_CALL = 3'd4;
   localparam logic [2:0] OP_RET  = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd6;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED, ST_FAULT} state_t;

   state_t state, state_nx;

   logic [PC_W-1:0]  lut   [2**LUT_AW];
   logic [PC_W-1:0]  stack [2**IDX_W];
   logic             lut_clr;
   logic [PC_W-1:0]  lut_tgt;
   logic [PC_W-1:0]  pc_inc;
   logic [IDX_W-1:0] push_idx;
   logic [IDX_W-1:0] top_idx;
   logic [PC_W-1:0]  pc_nx;
   logic [SP_W-1:0]  sp_nx;
   logic [CNT_W-1:0] cycle_nx;
   logic [CNT_W-1:0] instr_nx;
   logic             push;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign lut_tgt  = lut[target_idx];
   assign pc_inc   = PC + PC_W'(1);
   assign push_idx = sp[IDX_W-1:0];
   assign top_idx  = push_idx - IDX_W'(1);
   assign halt     = (state != ST_RUN);
   assign fault    = (state == ST_FAULT);

   always_comb begin
      state_nx = state;
      pc_nx    = PC;
      sp_nx    = sp;
      cycle_nx = cycle_ct;
      instr_nx = instr_ct;
      push     = 1'b0;
      if (start) begin
         state_nx = ST_RUN;
         pc_nx    = '0;
         sp_nx    = '0;
         cycle_nx = '0;
         instr_nx = '0;
      end else if (state == ST_RUN) begin
         cycle_nx = sat_inc(cycle_ct);
         if (!stall) begin
            instr_nx = sat_inc(instr_ct);
            case (op_kind)
               OP_JUMP: pc_nx = lut_tgt;
               OP_BEQ:  pc_nx = equal ? lut_tgt : pc_inc;
               OP_BNE:  pc_nx = equal ? pc_inc : lut_tgt;
               OP_CALL: begin
                  if (sp == SP_W'(STACK_D)) begin
                     state_nx = ST_FAULT;
                  end else begin
                     push  = 1'b1;
                     sp_nx = sp + SP_W'(1);
                     pc_nx = lut_tgt;
                  end
               end
               OP_RET: begin
                  if (sp == '0) begin
                     state_nx = ST_FAULT;
                  end else begin
                     sp_nx = sp - SP_W'(1);
                     pc_nx = stack[top_idx];
                  end
               end
               OP_HALT: state_nx = ST_HALTED;
               default: pc_nx = pc_inc;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         PC       <= '0;
         sp       <= '0;
         cycle_ct <= '0;
         instr_ct <= '0;
      end else begin
         state    <= state_nx;
         PC       <= pc_nx;
         sp       <= sp_nx;
         cycle_ct <= cycle_nx;
         instr_ct <= instr_nx;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) stack[push_idx] <= pc_inc;
   end

   // Registered clear request keeps the LUT itself free of reset while still
   // zeroing it on clock edges seen during (and just after) reset.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) lut_clr <= 1'b1;
      else          lut_clr <= 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (lut_clr) begin
         for (int i = 0; i < 2**LUT_AW; i++) lut[i] <= '0;
      end else if (lut_we && (state == ST_IDLE || state == ST_HALTED)) begin
         lut[lut_waddr] <= lut_wdata;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic        CLK = 1'b0;
   logic        reset_n;
   logic        start;
   logic        stall;
   logic [2:0]  op_kind;
   logic        equal;
   logic [2:0]  target_idx;
   logic        lut_we;
   logic [2:0]  lut_waddr;
   logic [9:0]  lut_wdata;

   logic [9:0]  PC;
   logic        halt;
   logic        fault;
   logic [2:0]  sp;
   logic [15:0] cycle_ct;
   logic [15:0] instr_ct;

   logic [3:0]  PC_s;
   logic        halt_s;
   logic        fault_s;
   logic [2:0]  sp_s;
   logic [3:0]  cycle_ct_s;
   logic [3:0]  instr_ct_s;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, BEQ = 3'd2, BNE = 3'd3,
                          CALL = 3'd4, RET = 3'd5, HLT = 3'd6;

   pc_sequencer u_dut (
      .CLK(CLK), .reset_n(reset_n), .start(start), .stall(stall),
      .op_kind(op_kind), .equal(equal), .target_idx(target_idx),
      .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
      .PC(PC), .halt(halt), .fault(fault), .sp(sp),
      .cycle_ct(cycle_ct), .instr_ct(instr_ct)
   );

   pc_sequencer #(.PC_W(4), .CNT_W(4)) u_small (
      .CLK(CLK), .reset_n(reset_n), .start(start), .stall(stall),
      .op_kind(op_kind), .equal(equal), .target_idx(target_idx),
      .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata[3:0]),
      .PC(PC_s), .halt(halt_s), .fault(fault_s), .sp(sp_s),
      .cycle_ct(cycle_ct_s), .instr_ct(instr_ct_s)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] op, input int n = 1);
      op_kind = op;
      step(n);
      op_kind = NXT;
   endtask

   task automatic lut_write(input logic [2:0] a, input logic [9:0] d);
      lut_we    = 1'b1;
      lut_waddr = a;
      lut_wdata = d;
      step();
      lut_we    = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; stall = 1'b0; op_kind = NXT; equal = 1'b0;
      target_idx = '0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
      step(2);
      chk("rst_pc", PC, 0);
      chk("rst_halt", halt, 1);
      chk("rst_fault", fault, 0);
      chk("rst_sp", sp, 0);
      reset_n = 1'b1;
      step();

      do_start();
      chk("start_halt", halt, 0);
      chk("start_pc", PC, 0);
      run_op(NXT, 3);
      chk("next3_pc", PC, 3);
      chk("next3_instr", instr_ct, 3);
      chk("next3_cycle", cycle_ct, 3);

      // asynchronous reset between clock edges
      reset_n = 1'b0;
      #1;
      chk("arst_pc", PC, 0);
      chk("arst_halt", halt, 1);
      chk("arst_cycle", cycle_ct, 0);
      chk("arst_instr", instr_ct, 0);
      #1 reset_n = 1'b1;
      step();

      lut_write(3'd2, 10'h040);
      lut_write(3'd1, 10'h100);

      do_start();
      run_op(NXT, 3);
      target_idx = 3'd2;
      equal = 1'b0; run_op(BEQ);
      chk("beq_nt_pc", PC, 4);
      equal = 1'b1; run_op(BEQ);
      chk("beq_t_pc", PC, 10'h040);
      equal = 1'b0; run_op(BNE);
      chk("bne_t_pc", PC, 10'h040);
      equal = 1'b1; run_op(BNE);
      chk("bne_nt_pc", PC, 10'h041);
      chk("br_instr", instr_ct, 7);

      do_start();
      run_op(NXT, 5);
      target_idx = 3'd1;
      run_op(CALL);
      chk("call_pc", PC, 10'h100);
      chk("call_sp", sp, 1);
      run_op(RET);
      chk("ret_pc", PC, 6);
      chk("ret_sp", sp, 0);

      stall = 1'b1;
      run_op(NXT, 2);
      stall = 1'b0;
      chk("stall_pc", PC, 6);
      chk("stall_cycle", cycle_ct, 9);
      chk("stall_instr", instr_ct, 7);

      run_op(CALL, 4);
      chk("nest_sp", sp, 4);
      chk("nest_fault", fault, 0);
      run_op(CALL);
      chk("ovf_fault", fault, 1);
      chk("ovf_halt", halt, 1);
      chk("ovf_pc", PC, 10'h100);
      chk("ovf_sp", sp, 4);
      chk("ovf_instr", instr_ct, 12);
      run_op(NXT, 2);
      chk("fault_frozen_cycle", cycle_ct, 14);
      chk("fault_frozen_pc", PC, 10'h100);

      do_start();
      chk("restart_fault", fault, 0);
      chk("restart_sp", sp, 0);
      run_op(RET);
      chk("udf_fault", fault, 1);
      chk("udf_pc", PC, 0);
      do_start();
      chk("udf_restart_fault", fault, 0);
      chk("udf_restart_pc", PC, 0);

      run_op(NXT, 7);
      run_op(HLT);
      chk("halt_flag", halt, 1);
      chk("halt_fault", fault, 0);
      chk("halt_pc", PC, 7);
      chk("halt_instr", instr_ct, 8);
      chk("halt_cycle", cycle_ct, 8);
      run_op(NXT, 3);
      chk("halted_pc", PC, 7);
      chk("halted_instr", instr_ct, 8);
      chk("halted_cycle", cycle_ct, 8);

      // LUT write attempted while running must be dropped
      do_start();
      lut_write(3'd2, 10'h3FF);
      target_idx = 3'd2;
      run_op(JMP);
      chk("lut_run_we_pc", PC, 10'h040);

      do_start();
      run_op(NXT, 15);
      chk("small_pc15", PC_s, 15);
      run_op(NXT);
      chk("small_wrap_pc", PC_s, 0);
      chk("small_wrap_fault", fault_s, 0);
      run_op(NXT, 4);
      chk("small_sat_cycle", cycle_ct_s, 15);
      chk("small_sat_instr", instr_ct_s, 15);
      chk("small_pc20", PC_s, 4);
      chk("big_cycle20", cycle_ct, 20);
      chk("big_pc20", PC, 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
